trng_collector: RTL and testbench
=================================

// Module: trng_collector
// PURPOSE
//  Consumer side of the ring-oscillator TRNG bit source. Drives the TRNG enable, samples its
//  synchronised 1-bit output at a programmable rate, optionally debiases with a von Neumann
//  corrector, and packs accepted bits into WIDTH-bit words. Words are delivered over a
//  valid/ready handshake to the crypto core. A repetition-count health test on raw samples
//  raises a sticky alarm and stops delivery.
// PARAMETERS
//  WIDTH       32  output word width in bits (>=2)
//  SAMPLE_DIV  8   clock cycles between raw samples (>=1; 1 = sample every cycle)
//  WARMUP      4   raw samples discarded after each enable (covers the sync pipeline, >=1)
//  REP_LIMIT   32  consecutive identical raw samples that trip the alarm (>=2)
//  VN_EN       1   1 = von Neumann debiasing on, 0 = raw samples packed directly
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      collection enable (level)
//  trng_bit   in   1      synchronised TRNG output bit
//  trng_en    out  1      enable to the TRNG oscillator
//  rnd_data   out  WIDTH  random word; stable while rnd_valid=1
//  rnd_valid  out  1      word available
//  rnd_ready  in   1      consumer accepts the word when rnd_valid & rnd_ready
//  alarm      out  1      sticky health-test failure
//  alarm_clr  in   1      clears the alarm (effective only in ALARM)
// BEHAVIOUR
//  Reset: state IDLE; trng_en, rnd_valid, alarm = 0; rnd_data = 0; all counters and the VN
//   pair register cleared.
//  Sample tick: a divider counts 0..SAMPLE_DIV-1 while in WARMUP or COLLECT. The tick fires
//   on the cycle the count equals SAMPLE_DIV-1; trng_bit is sampled on that edge. The
//   divider clears on entry to WARMUP and holds in all other states.
//  FSM:
//   IDLE:    trng_en=0. en=1 -> WARMUP.
//   WARMUP:  trng_en=1. Discards WARMUP ticks, then -> COLLECT. en=0 -> IDLE.
//   COLLECT: trng_en=1. Each tick is a raw sample:
//            VN_EN=1: samples are paired (first, second). Pair 01 accepts bit 0, pair 10
//            accepts bit 1; 00 and 11 are discarded.
//            VN_EN=0: every sample is accepted.
//            Accepted bit: shift = {shift[WIDTH-2:0], bit}, so the first bit ends in the MSB.
//            On the WIDTH-th accepted bit: rnd_data <= shift word, rnd_valid <= 1 on the next
//            edge, -> HOLD.
//            en=0 -> IDLE; the partial word and the VN half-pair are discarded.
//   HOLD:    rnd_valid=1, rnd_data frozen, sampling paused, trng_en=en.
//            On handshake: rnd_valid <= 0. Then -> COLLECT if en=1, else -> IDLE. Returning
//            to COLLECT does not warm up again.
//            rnd_valid never drops without a handshake, even if en falls.
//   ALARM:   trng_en=0, rnd_valid=0, alarm=1. Sampling stops and the partial word is
//            discarded. alarm_clr=1 -> IDLE with alarm <= 0.
//  Health test (COLLECT raw samples only, before VN):
//   - Run counter is 1 on the first sample and after any change of value; +1 on each repeat.
//   - Saturates at REP_LIMIT.
//   - When it reaches REP_LIMIT: alarm <= 1 and -> ALARM on that edge. No word completes on
//     that sample.
//   - The counter persists across HOLD. It clears on entry to IDLE.
//   - If trip and word-completion coincide, the alarm wins.
//   - If the trip occurs while a word is held, the held word is dropped.
//  Simultaneous events: in HOLD, a handshake and en=0 in the same cycle -> IDLE.
//   alarm_clr outside ALARM is ignored.
//  Reset mid-operation: immediate return to reset values; any held word is lost.
//  Latency (VN_EN=0, en held high): first rnd_valid appears
//   (WARMUP+WIDTH)*SAMPLE_DIV + 1 cycles after en rises.
// TESTING
//  1 Reset: during and after rst_n low, trng_en=0, rnd_valid=0, alarm=0, rnd_data=0.
//  2 Packing: VN_EN=0, WIDTH=8, SAMPLE_DIV=1, WARMUP=4. en=1; after 4 ticks drive
//    1,0,1,1,0,0,1,0 -> rnd_valid=1, rnd_data=8'hB2 at cycle 13.
//  3 VN: VN_EN=1, WIDTH=8. Drive pairs 01,10,00,11,10,10,01,01,10,01 -> rnd_data=8'b01110010.
//  4 Backpressure: hold rnd_ready=0 for 20 cycles -> rnd_data/rnd_valid stable. Drop en
//    during the hold -> word is still delivered, then IDLE with trng_en=0.
//  5 Health: REP_LIMIT=32, drive trng_bit=1 constantly -> alarm=1 at the 32nd raw sample,
//    trng_en=0, no word. Pulse alarm_clr -> alarm=0, IDLE.
//  6 Abort: en low mid-word after 5 accepted bits, then high -> warm-up repeats and the next
//    word contains only new bits.

Source files
------------

// File: rtl/trng_collector.sv
// Ring-oscillator TRNG consumer: rate-divided sampling, optional von Neumann
// debiasing, word packing with valid/ready delivery and a repetition-count alarm.
`timescale 1ns/1ps
module trng_collector #(
    parameter int WIDTH      = 32,
    parameter int SAMPLE_DIV = 8,
    parameter int WARMUP     = 4,
    parameter int REP_LIMIT  = 32,
    parameter int VN_EN      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             trng_bit,
    output logic             trng_en,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             alarm,
    input  logic             alarm_clr
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_ALARM
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic             last_q, last_d;
    logic             vn_have_q, vn_have_d;
    logic             vn_first_q, vn_first_d;

    logic             sampling;
    logic             tick;
    logic [RW-1:0]    run_next;
    logic             acc;
    logic             acc_bit;
    logic [WIDTH-1:0] shift_full;

    assign sampling = (state_q == S_WARMUP) || (state_q == S_COLLECT);
    assign tick     = sampling && (div_q == DIV_LAST);

    assign trng_en   = sampling || ((state_q == S_HOLD) && en);
    assign rnd_valid = (state_q == S_HOLD);
    assign alarm     = (state_q == S_ALARM);
    assign rnd_data  = data_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        warm_d     = warm_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        rep_d      = rep_q;
        last_d     = last_q;
        vn_have_d  = vn_have_q;
        vn_first_d = vn_first_q;
        acc        = 1'b0;
        acc_bit    = 1'b0;
        shift_full = '0;

        if (sampling) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end

        if ((rep_q == '0) || (trng_bit != last_q)) begin
            run_next = RW'(1);
        end else if (rep_q == REP_MAX) begin
            run_next = REP_MAX;
        end else begin
            run_next = rep_q + RW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WARMUP;
                    div_d   = '0;
                    warm_d  = '0;
                end
            end
            S_WARMUP: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (warm_q == WARM_LAST) begin
                        state_d = S_COLLECT;
                    end else begin
                        warm_d = warm_q + WW'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    rep_d  = run_next;
                    last_d = trng_bit;
                    if (VN_EN != 0) begin
                        // second of a pair decides; the first sample is the kept bit
                        vn_have_d  = !vn_have_q;
                        vn_first_d = trng_bit;
                        acc        = vn_have_q && (vn_first_q != trng_bit);
                        acc_bit    = vn_first_q;
                    end else begin
                        acc     = 1'b1;
                        acc_bit = trng_bit;
                    end
                    shift_full = {shift_q, acc_bit};
                    if (run_next == REP_MAX) begin
                        state_d = S_ALARM;
                    end else if (acc) begin
                        shift_d = shift_full[WIDTH-2:0];
                        if (bcnt_q == BIT_LAST) begin
                            data_d  = shift_full;
                            bcnt_d  = '0;
                            state_d = S_HOLD;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
            end
            S_HOLD: begin
                if (rnd_ready) begin
                    state_d = en ? S_COLLECT : S_IDLE;
                end
            end
            S_ALARM: begin
                if (alarm_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // leaving active collection drops the partial word and any half pair
        if ((state_d != state_q) &&
            ((state_d == S_IDLE) || (state_d == S_ALARM))) begin
            bcnt_d     = '0;
            shift_d    = '0;
            vn_have_d  = 1'b0;
            vn_first_d = 1'b0;
            if (state_d == S_IDLE) begin
                rep_d  = '0;
                last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            warm_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            rep_q      <= '0;
            last_q     <= 1'b0;
            vn_have_q  <= 1'b0;
            vn_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            warm_q     <= warm_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            rep_q      <= rep_d;
            last_q     <= last_d;
            vn_have_q  <= vn_have_d;
            vn_first_q <= vn_first_d;
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: a raw-packing instance (every cycle a sample) and a
// von Neumann instance (sample every 3 cycles), checked against a sample-level model.
`timescale 1ns/1ps
module tb_trng_collector;

    localparam int W  = 8;
    localparam int WU = 4;
    localparam int RL = 32;

    typedef logic sq_t[$];

    logic clk = 1'b0;
    logic rst_n;

    logic         en_r, bit_r, rdy_r, clr_r;
    logic         ten_r, val_r, alm_r;
    logic [W-1:0] dat_r;

    logic         en_v, bit_v, rdy_v, clr_v;
    logic         ten_v, val_v, alm_v;
    logic [W-1:0] dat_v;

    int   n_chk = 0;
    int   n_fail = 0;
    int   run_len = 0;
    logic run_val = 1'b0;

    always #5 clk = ~clk;

    trng_collector #(
        .WIDTH(W), .SAMPLE_DIV(1), .WARMUP(WU), .REP_LIMIT(RL), .VN_EN(0)
    ) u_raw (
        .clk(clk), .rst_n(rst_n), .en(en_r), .trng_bit(bit_r),
        .trng_en(ten_r), .rnd_data(dat_r), .rnd_valid(val_r),
        .rnd_ready(rdy_r), .alarm(alm_r), .alarm_clr(clr_r)
    );

    trng_collector #(
        .WIDTH(W), .SAMPLE_DIV(3), .WARMUP(WU), .REP_LIMIT(RL), .VN_EN(1)
    ) u_vn (
        .clk(clk), .rst_n(rst_n), .en(en_v), .trng_bit(bit_v),
        .trng_en(ten_v), .rnd_data(dat_v), .rnd_valid(val_v),
        .rnd_ready(rdy_v), .alarm(alm_v), .alarm_clr(clr_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    // von Neumann on a sample stream: non-overlapping pairs, keep first if they differ
    function automatic sq_t vn_accept(input sq_t s);
        sq_t a;
        for (int i = 0; i + 1 < s.size(); i += 2) begin
            if (s[i] != s[i+1]) a.push_back(s[i]);
        end
        return a;
    endfunction

    function automatic logic [W-1:0] pack(input sq_t a);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = a[i];
        return w;
    endfunction

    // keeps random stimulus below the repetition limit
    function automatic logic safe_bit(input logic b);
        if ((run_len >= RL - 1) && (b == run_val)) return ~b;
        return b;
    endfunction

    task automatic note(input logic b);
        if ((run_len == 0) || (b != run_val)) run_len = 1;
        else run_len++;
        run_val = b;
    endtask

    task automatic gen_raw(output sq_t b);
        logic x;
        b.delete();
        for (int i = 0; i < W; i++) begin
            x = safe_bit(rnd());
            note(x);
            b.push_back(x);
        end
    endtask

    task automatic raw_start();
        @(negedge clk);
        en_r = 1'b1;
        for (int i = 0; i < WU; i++) begin
            @(negedge clk);
            rdy_r = 1'b0;
            bit_r = rnd();
            if (i == 1) chk("raw_warm_ten", 32'(ten_r), 32'd1);
        end
    endtask

    task automatic raw_word(input sq_t b, input string tag);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            rdy_r = 1'b0;
            bit_r = b[i];
            if (i == W - 1) chk({tag, "_early"}, 32'(val_r), 32'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(val_r), 32'd1);
        chk({tag, "_data"}, 32'(dat_r), 32'(pack(b)));
    endtask

    task automatic raw_hs();
        @(negedge clk);
        rdy_r = 1'b1;
        @(posedge clk);
        #1;
        chk("raw_hs_valid", 32'(val_r), 32'd0);
    endtask

    task automatic vn_sample(input logic b);
        @(negedge clk);
        rdy_v = 1'b0;
        bit_v = b;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sq_t          b;
        sq_t          q;
        sq_t          acc;
        logic [W-1:0] d0;
        logic [7:0]   pat8;
        logic [19:0]  pat20;
        logic         x;

        rst_n = 1'b0;
        en_r = 1'b1; bit_r = 1'b1; rdy_r = 1'b0; clr_r = 1'b0;
        en_v = 1'b1; bit_v = 1'b1; rdy_v = 1'b0; clr_v = 1'b0;

        // reset holds everything quiet even with en high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ten_r", 32'(ten_r), 32'd0);
            chk("rst_val_r", 32'(val_r), 32'd0);
            chk("rst_alm_r", 32'(alm_r), 32'd0);
            chk("rst_dat_r", 32'(dat_r), 32'd0);
            chk("rst_ten_v", 32'(ten_v), 32'd0);
            chk("rst_val_v", 32'(val_v), 32'd0);
            chk("rst_alm_v", 32'(alm_v), 32'd0);
            chk("rst_dat_v", 32'(dat_v), 32'd0);
        end
        en_r = 1'b0;
        en_v = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ten_r", 32'(ten_r), 32'd0);
        chk("post_rst_val_r", 32'(val_r), 32'd0);

        // fixed packing pattern, valid exactly 13 edges after en
        run_len = 0;
        pat8 = 8'b10110010;
        b.delete();
        for (int i = 0; i < W; i++) begin
            b.push_back(pat8[7-i]);
            note(pat8[7-i]);
        end
        raw_start();
        raw_word(b, "pack_fixed");
        chk("pack_b2", 32'(dat_r), 32'hB2);

        for (int w = 0; w < 3; w++) begin
            raw_hs();
            gen_raw(b);
            raw_word(b, "pack_rand");
        end

        // backpressure, ignored alarm_clr, en dropped while held
        d0 = dat_r;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(val_r), 32'd1);
            chk("bp_data", 32'(dat_r), 32'(d0));
            chk("bp_ten", 32'(ten_r), (i <= 8) ? 32'd1 : 32'd0);
            chk("bp_alarm", 32'(alm_r), 32'd0);
            clr_r = (i == 4);
            if (i == 8) en_r = 1'b0;
        end
        raw_hs();
        chk("bp_idle_ten", 32'(ten_r), 32'd0);
        @(negedge clk);
        rdy_r = 1'b0;
        chk("bp_idle_valid", 32'(val_r), 32'd0);
        run_len = 0;

        // abort after 5 accepted bits; next word must hold only new bits
        raw_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_r = 1'b1;
            note(1'b1);
        end
        @(negedge clk);
        en_r = 1'b0;
        @(negedge clk);
        chk("abort_ten", 32'(ten_r), 32'd0);
        chk("abort_valid", 32'(val_r), 32'd0);
        run_len = 0;
        raw_start();
        gen_raw(b);
        raw_word(b, "abort_word");
        @(negedge clk);
        rdy_r = 1'b1;
        en_r = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_hs_valid", 32'(val_r), 32'd0);
        chk("abort_hs_ten", 32'(ten_r), 32'd0);
        @(negedge clk);
        rdy_r = 1'b0;
        run_len = 0;

        // fixed von Neumann pattern
        @(negedge clk);
        en_v = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < WU; i++) vn_sample(rnd());
        pat20 = 20'b01_10_00_11_10_10_01_01_10_01;
        q.delete();
        for (int i = 0; i < 20; i++) begin
            x = pat20[19-i];
            note(x);
            vn_sample(x);
            q.push_back(x);
            acc = vn_accept(q);
            chk("vn_fixed_valid", 32'(val_v), 32'(acc.size() == W));
        end
        chk("vn_fixed_data", 32'(dat_v), 32'h72);

        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            rdy_v = 1'b1;
            @(posedge clk);
            #1;
            chk("vn_hs_valid", 32'(val_v), 32'd0);
            q.delete();
            acc.delete();
            for (int g = 0; (g < 400) && (acc.size() < W); g++) begin
                x = safe_bit(rnd());
                note(x);
                vn_sample(x);
                q.push_back(x);
                acc = vn_accept(q);
                chk("vn_rand_valid", 32'(val_v), 32'(acc.size() == W));
            end
            chk("vn_rand_done", 32'(acc.size()), 32'(W));
            if (acc.size() == W) chk("vn_rand_data", 32'(dat_v), 32'(pack(acc)));
            chk("vn_rand_alarm", 32'(alm_v), 32'd0);
        end

        // handshake and en low together -> idle
        @(negedge clk);
        rdy_v = 1'b1;
        en_v = 1'b0;
        @(posedge clk);
        #1;
        chk("vn_sim_valid", 32'(val_v), 32'd0);
        chk("vn_sim_ten", 32'(ten_v), 32'd0);
        @(negedge clk);
        rdy_v = 1'b0;
        run_len = 0;

        // constant ones: 32nd collected sample trips the alarm, no word
        @(negedge clk);
        en_v = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < WU; i++) vn_sample(1'b1);
        for (int k = 1; k <= RL; k++) begin
            vn_sample(1'b1);
            chk("hl_alarm", 32'(alm_v), 32'(k == RL));
            chk("hl_valid", 32'(val_v), 32'd0);
        end
        chk("hl_ten", 32'(ten_v), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hl_sticky", 32'(alm_v), 32'd1);
            chk("hl_sticky_ten", 32'(ten_v), 32'd0);
        end
        @(negedge clk);
        clr_v = 1'b1;
        @(posedge clk);
        #1;
        chk("hl_clr_alarm", 32'(alm_v), 32'd0);
        chk("hl_clr_ten", 32'(ten_v), 32'd0);
        @(negedge clk);
        clr_v = 1'b0;
        en_v = 1'b0;

        // asynchronous reset drops a held word at once
        run_len = 0;
        raw_start();
        gen_raw(b);
        raw_word(b, "mid_word");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(val_r), 32'd0);
        chk("mid_rst_data", 32'(dat_r), 32'd0);
        chk("mid_rst_ten", 32'(ten_r), 32'd0);
        en_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
